muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU.
- Consumes the same forwarded operand pair as the ALU.
- Produces a registered 32-bit result with a valid pulse.
- Holds busy while computing so the hazard unit stalls IF/ID/EX; the result joins the ALU result at the EX/MEM mux.

---
 rtl/muldiv_pkg.sv | 11 +
 rtl/div_core.sv | 36 +++
 rtl/muldiv_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;
   localparam int MULDIV_DATA_WIDTH = 32;
   localparam int MULDIV_DIV_ITER   = MULDIV_DATA_WIDTH;

   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } muldiv_op_e;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} muldiv_state_e;
endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider: one quotient bit per step, MSB first.
module div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH:0]   trial;
   logic             fits;

   // partial remainder with the next dividend bit shifted in from the quotient register
   assign trial = {remainder, quotient[WIDTH-1]};
   assign fits  = trial >= {1'b0, dvsr};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         quotient  <= '0;
         remainder <= '0;
         dvsr      <= '0;
      end else if (load) begin
         quotient  <= dividend;
         remainder <= '0;
         dvsr      <= divisor;
      end else if (step) begin
         remainder <= fits ? WIDTH'(trial - {1'b0, dvsr}) : trial[WIDTH-1:0];
         quotient  <= {quotient[WIDTH-2:0], fits};
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, sign handling, fast paths and multiplier.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = MULDIV_DATA_WIDTH,
   parameter int DIV_ITER   = MULDIV_DIV_ITER
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   input  muldiv_op_e            MulDivOp_i,
   input  logic [DATA_WIDTH-1:0] operand1_i,
   input  logic [DATA_WIDTH-1:0] operand2_i,
   input  logic                  flush_i,
   output logic                  ready_o,
   output logic                  busy_o,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] result_o
);
   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DIV_ITER) + 1;
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIV_ITER - 1);
   localparam logic [W-1:0]     MIN_S  = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0]     ALL1   = '1;

   muldiv_state_e    state;
   logic [CNT_W-1:0] cnt;
   muldiv_op_e       op_q;
   logic [W-1:0]     a_q, b_q;
   logic [2*W-1:0]   prod_q, prod_d;
   logic [W-1:0]     quo, rem, q_fix, r_fix, res_d;
   logic [W-1:0]     dividend_abs, divisor_abs;
   logic [W:0]       ext1, ext2;
   logic             accept, in_div, in_signed, in_fast, ovf_q;

   assign ready_o = (state == S_IDLE);
   assign busy_o  = (state == S_MUL) || (state == S_DIV);
   assign accept  = valid_i && ready_o && !flush_i;

   assign in_div       = MulDivOp_i >= OP_DIV;
   assign in_signed    = (MulDivOp_i == OP_DIV) || (MulDivOp_i == OP_REM);
   assign in_fast      = in_div && ((operand2_i == '0) ||
                         (in_signed && operand1_i == MIN_S && operand2_i == ALL1));
   assign dividend_abs = (in_signed && operand1_i[W-1]) ? -operand1_i : operand1_i;
   assign divisor_abs  = (in_signed && operand2_i[W-1]) ? -operand2_i : operand2_i;

   div_core #(.WIDTH(W)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .step      (state == S_DIV),
      .dividend  (dividend_abs),
      .divisor   (divisor_abs),
      .quotient  (quo),
      .remainder (rem)
   );

   // The top two bits of the 66-bit product are never read, so only 64 are formed.
   assign ext1   = {(op_q == OP_MULH || op_q == OP_MULHSU) & a_q[W-1], a_q};
   assign ext2   = {(op_q == OP_MULH) & b_q[W-1], b_q};
   assign prod_d = $signed({{(W-1){ext1[W]}}, ext1}) * $signed({{(W-1){ext2[W]}}, ext2});

   assign ovf_q = (op_q == OP_DIV || op_q == OP_REM) && a_q == MIN_S && b_q == ALL1;
   assign q_fix = (op_q == OP_DIV && (a_q[W-1] ^ b_q[W-1])) ? -quo : quo;
   assign r_fix = (op_q == OP_REM && a_q[W-1]) ? -rem : rem;

   always_comb begin
      res_d = '0;
      case (op_q)
         OP_MUL:                       res_d = prod_q[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_q[2*W-1:W];
         OP_DIV, OP_DIVU:              res_d = (b_q == '0) ? ALL1 : (ovf_q ? MIN_S : q_fix);
         OP_REM, OP_REMU:              res_d = (b_q == '0) ? a_q  : (ovf_q ? '0 : r_fix);
         default:                      res_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op_q     <= OP_MUL;
         a_q      <= '0;
         b_q      <= '0;
         prod_q   <= '0;
         valid_o  <= 1'b0;
         result_o <= '0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            S_IDLE: if (accept) begin
               op_q  <= MulDivOp_i;
               a_q   <= operand1_i;
               b_q   <= operand2_i;
               cnt   <= '0;
               state <= !in_div ? S_MUL : (in_fast ? S_DONE : S_DIV);
            end
            S_MUL: begin
               prod_q <= prod_d;
               state  <= flush_i ? S_IDLE : S_DONE;
            end
            S_DIV: begin
               cnt <= cnt + 1'b1;
               if (flush_i)          state <= S_IDLE;
               else if (cnt == LAST) state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
               if (!flush_i) begin
                  valid_o  <= 1'b1;
                  result_o <= res_d;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
